ram_sp_init: RTL and testbench

- Parametrised single-port synchronous RAM; successor to the fixed 4x4 masked RAM.
- Generalised address/data width, masked write and read data, and selectable read latency (1 or 2).
- Adds a valid strobe, a hardware clear sequencer that initialises every location after reset or on request, and a BUSY flag.
- Used as a generic scratch/lookup store by datapath blocks that need a known memory state without testbench preload.

---
 rtl/ram_sp_init.sv | 124 ++++++++++++
 tb/tb_ram_sp_init.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_init.sv
// Single-port synchronous RAM with AND-masked data, 1- or 2-cycle read latency
// and a hardware clear sweep that initialises every location after reset or CLR.
module ram_sp_init #(
  parameter int            AW       = 4,
  parameter int            DW       = 4,
  parameter logic [DW-1:0] MASK     = {DW{1'b1}},
  parameter logic [DW-1:0] INIT_VAL = '0,
  parameter int            RD_LAT   = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  input  logic          EN,
  input  logic          WR,
  input  logic          CLR,
  output logic [DW-1:0] Q,
  output logic          QV,
  output logic          BUSY
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {INIT, READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mem [DEPTH];

  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic          rdReq;

  logic          rd1Valid_q;
  logic [DW-1:0] rd1Data_q;

  // The sweep owns the write port while INIT; CLR always beats a same-cycle access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    memWe   = 1'b0;
    memAddr = A;
    memData = D & MASK;
    rdReq   = 1'b0;
    case (state_q)
      INIT: begin
        memWe   = 1'b1;
        memAddr = cnt_q;
        memData = INIT_VAL & MASK;
        if (CLR) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = READY;
        end
      end
      READY: begin
        if (CLR) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (EN) begin
          if (WR) memWe = 1'b1;
          else    rdReq = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY = (state_q == INIT);

  always_ff @(posedge CLK) begin
    if (memWe) mem[memAddr] <= memData;
  end

  // Data registers only load on a valid read so Q holds while QV is low.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd1Valid_q <= 1'b0;
      rd1Data_q  <= '0;
    end else begin
      rd1Valid_q <= rdReq;
      if (rdReq) rd1Data_q <= mem[A] & MASK;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign Q  = rd1Data_q;
    assign QV = rd1Valid_q;
  end else if (RD_LAT == 2) begin : g_lat2
    logic          rd2Valid_q;
    logic [DW-1:0] rd2Data_q;

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        rd2Valid_q <= 1'b0;
        rd2Data_q  <= '0;
      end else begin
        rd2Valid_q <= rd1Valid_q;
        if (rd1Valid_q) rd2Data_q <= rd1Data_q;
      end
    end

    assign Q  = rd2Data_q;
    assign QV = rd2Valid_q;
  end else begin : g_bad_lat
    $error("ram_sp_init: RD_LAT must be 1 or 2");
  end

endmodule

// File: tb/tb_ram_sp_init.sv
// Directed bench for ram_sp_init: one RD_LAT=1 and one RD_LAT=2 instance
// share the same stimulus; table vectors plus hand-written multi-cycle sequences.
module tb_ram_sp_init;

  logic       clk;
  logic       rstn;
  logic [3:0] a;
  logic [7:0] d;
  logic       en, wr, clr;
  logic [7:0] q1, q2;
  logic       qv1, qv2, busy1, busy2;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic       en;
    logic       wr;
    logic       clr;
    logic [3:0] a;
    logic [7:0] d;
    logic       expQv;
    logic [7:0] expQ;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  ram_sp_init #(.AW(4), .DW(8), .MASK(8'h3F), .INIT_VAL(8'hA5), .RD_LAT(1)) dut1 (
    .CLK(clk), .RSTN(rstn), .A(a), .D(d), .EN(en), .WR(wr), .CLR(clr),
    .Q(q1), .QV(qv1), .BUSY(busy1)
  );

  ram_sp_init #(.AW(4), .DW(8), .MASK(8'h3F), .INIT_VAL(8'hA5), .RD_LAT(2)) dut2 (
    .CLK(clk), .RSTN(rstn), .A(a), .D(d), .EN(en), .WR(wr), .CLR(clr),
    .Q(q2), .QV(qv2), .BUSY(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic w, input logic c,
                               input logic [3:0] addr, input logic [7:0] data);
    en  = e;
    wr  = w;
    clr = c;
    a   = addr;
    d   = data;
  endtask

  task automatic waitBusy(output int n);
    n = 0;
    while (busy1 && n < 40) begin
      step();
      n++;
    end
  endtask

  function automatic void addVec(input logic e, input logic w, input logic c, input logic [3:0] addr,
                                 input logic [7:0] data, input logic qv, input logic [7:0] qe,
                                 input logic b);
    vec_t v;
    v.en = e; v.wr = w; v.clr = c; v.a = addr; v.d = data;
    v.expQv = qv; v.expQ = qe; v.expBusy = b;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;
    logic qvSeen;

    // Expected outputs are those of the RD_LAT=1 instance just after the edge.
    for (int i = 0; i < 16; i++) addVec(1, 0, 0, 4'(i), 8'h00, 1, 8'h25, 0);
    addVec(1, 1, 0, 4'd3,  8'hFF, 0, 8'h25, 0);
    addVec(1, 0, 0, 4'd3,  8'h00, 1, 8'h3F, 0);
    addVec(1, 0, 0, 4'd4,  8'h00, 1, 8'h25, 0);
    addVec(0, 0, 0, 4'd0,  8'h00, 0, 8'h25, 0);
    addVec(1, 1, 0, 4'd5,  8'h40, 0, 8'h25, 0);
    addVec(1, 0, 0, 4'd5,  8'h00, 1, 8'h00, 0);
    addVec(1, 1, 0, 4'd15, 8'hC7, 0, 8'h00, 0);
    addVec(1, 0, 0, 4'd15, 8'h00, 1, 8'h07, 0);
    addVec(0, 0, 0, 4'd15, 8'h00, 0, 8'h07, 0);

    rstn = 1'b0;
    applyStimulus(0, 0, 0, 4'd0, 8'h00);
    #1;
    checkOutput("reset q1", q1, 8'h00);
    checkOutput("reset qv1", qv1, 1'b0);
    checkOutput("reset busy1", busy1, 1'b1);
    checkOutput("reset qv2", qv2, 1'b0);
    step();
    step();
    rstn = 1'b1;
    waitBusy(n);
    checkOutput("initial sweep edges", n, 16);
    checkOutput("initial busy2", busy2, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].wr, vecs[i].clr, vecs[i].a, vecs[i].d);
      step();
      checkOutput($sformatf("vec%0d qv", i), qv1, vecs[i].expQv);
      checkOutput($sformatf("vec%0d q", i), q1, vecs[i].expQ);
      checkOutput($sformatf("vec%0d busy", i), busy1, vecs[i].expBusy);
    end

    // Two-stage read pipeline: three back-to-back reads.
    applyStimulus(1, 1, 0, 4'd1, 8'h11); step();
    applyStimulus(1, 1, 0, 4'd2, 8'h12); step();
    applyStimulus(1, 1, 0, 4'd3, 8'h13); step();
    applyStimulus(1, 0, 0, 4'd1, 8'h00); step();
    checkOutput("lat2 first edge qv2", qv2, 1'b0);
    checkOutput("lat2 first edge q2 held", q2, 8'h07);
    checkOutput("lat1 read1 q1", q1, 8'h11);
    applyStimulus(1, 0, 0, 4'd2, 8'h00); step();
    checkOutput("lat2 read1 qv2", qv2, 1'b1);
    checkOutput("lat2 read1 q2", q2, 8'h11);
    applyStimulus(1, 0, 0, 4'd3, 8'h00); step();
    checkOutput("lat2 read2 qv2", qv2, 1'b1);
    checkOutput("lat2 read2 q2", q2, 8'h12);
    applyStimulus(0, 0, 0, 4'd0, 8'h00); step();
    checkOutput("lat2 read3 qv2", qv2, 1'b1);
    checkOutput("lat2 read3 q2", q2, 8'h13);
    step();
    checkOutput("lat2 after qv2", qv2, 1'b0);
    checkOutput("lat2 after q2 held", q2, 8'h13);

    // Read in flight when CLR arrives, then a write during the sweep.
    applyStimulus(1, 1, 0, 4'd3, 8'hFF); step();
    applyStimulus(1, 0, 0, 4'd3, 8'h00); step();
    checkOutput("pre-clr read q1", q1, 8'h3F);
    checkOutput("pre-clr read qv1", qv1, 1'b1);
    applyStimulus(0, 0, 1, 4'd0, 8'h00); step();
    checkOutput("clr inflight qv2", qv2, 1'b1);
    checkOutput("clr inflight q2", q2, 8'h3F);
    checkOutput("clr qv1 low", qv1, 1'b0);
    checkOutput("clr busy", busy1, 1'b1);
    n = 0;
    qvSeen = 1'b0;
    while (busy1 && n < 40) begin
      if (n == 10) applyStimulus(1, 1, 0, 4'd0, 8'h3F);
      else         applyStimulus(0, 0, 0, 4'd0, 8'h00);
      step();
      n++;
      qvSeen = qvSeen | qv1 | qv2;
    end
    applyStimulus(0, 0, 0, 4'd0, 8'h00);
    checkOutput("clr sweep edges", n, 16);
    checkOutput("qv during sweep", qvSeen, 1'b0);
    applyStimulus(1, 0, 0, 4'd0, 8'h00); step();
    checkOutput("busy write dropped", q1, 8'h25);
    applyStimulus(1, 0, 0, 4'd3, 8'h00); step();
    checkOutput("post-clr read A3", q1, 8'h25);

    // CLR together with a read: the read is dropped.
    applyStimulus(1, 0, 1, 4'd3, 8'h00); step();
    checkOutput("clr+read qv1", qv1, 1'b0);
    checkOutput("clr+read busy", busy1, 1'b1);
    applyStimulus(0, 0, 0, 4'd0, 8'h00); step();
    checkOutput("clr+read qv2", qv2, 1'b0);
    waitBusy(n);
    checkOutput("clr+read sweep rest", n, 15);

    // CLR with a write, then CLR again at cnt=7 restarts the sweep.
    applyStimulus(1, 1, 1, 4'd6, 8'h3C); step();
    checkOutput("clr+write busy", busy1, 1'b1);
    applyStimulus(0, 0, 0, 4'd0, 8'h00);
    for (int i = 0; i < 7; i++) step();
    checkOutput("mid-sweep busy", busy1, 1'b1);
    applyStimulus(0, 0, 1, 4'd0, 8'h00); step();
    applyStimulus(0, 0, 0, 4'd0, 8'h00);
    waitBusy(n);
    checkOutput("restarted sweep edges", n, 16);

    // Asynchronous reset with a read in flight.
    applyStimulus(1, 0, 0, 4'd3, 8'h00); step();
    checkOutput("pre-reset q1", q1, 8'h25);
    applyStimulus(0, 0, 0, 4'd0, 8'h00);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async rst q1", q1, 8'h00);
    checkOutput("async rst qv1", qv1, 1'b0);
    checkOutput("async rst busy1", busy1, 1'b1);
    checkOutput("async rst busy2", busy2, 1'b1);
    step();
    checkOutput("pending read lost qv2", qv2, 1'b0);
    checkOutput("pending read lost q2", q2, 8'h00);
    rstn = 1'b1;
    waitBusy(n);
    checkOutput("sweep after read reset", n, 16);

    // Asynchronous reset in the middle of a sweep.
    applyStimulus(1, 0, 0, 4'd3, 8'h00); step();
    applyStimulus(0, 0, 1, 4'd0, 8'h00); step();
    applyStimulus(0, 0, 0, 4'd0, 8'h00);
    for (int i = 0; i < 5; i++) step();
    #2 rstn = 1'b0;
    #1;
    checkOutput("sweep rst q1", q1, 8'h00);
    checkOutput("sweep rst busy1", busy1, 1'b1);
    step();
    rstn = 1'b1;
    waitBusy(n);
    checkOutput("sweep after sweep reset", n, 16);
    applyStimulus(1, 0, 0, 4'd3, 8'h00); step();
    checkOutput("final read q1", q1, 8'h25);
    checkOutput("final read qv1", qv1, 1'b1);
    applyStimulus(0, 0, 0, 4'd0, 8'h00); step();
    checkOutput("final read q2", q2, 8'h25);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
